// File: rtl/bus_responder_if.sv
// CPU-side bus bundle for bus_responder.
// The CPU drives address/control/write data; the target returns read data.
`timescale 1ns/1ps
interface bus_responder_if;
    logic [15:0] address;
    logic        read_write;
    logic [7:0]  data_write;
    logic [7:0]  data_read;

    modport master (
        output address, read_write, data_write,
        input  data_read
    );
    modport slave (
        input  address, read_write, data_write,
        output data_read
    );
endinterface

// File: rtl/bus_responder.sv
// Memory-mapped CPU target: RAM, prescaled down-counting timer with irq,
// 8-bit GPIO and fixed vector bytes. Reads are combinational.
`timescale 1ns/1ps
module bus_responder #(
    parameter int          RAM_DEPTH    = 2048,
    parameter logic [15:0] RESET_VECTOR = 16'h0200,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0300
) (
    input  logic             clk,
    input  logic             rst,
    bus_responder_if.slave   bus,
    input  logic [7:0]       gpio_in,
    output logic [7:0]       gpio_out,
    output logic             irq
);
    localparam int          AW      = $clog2(RAM_DEPTH);
    localparam logic [16:0] RAM_TOP = 17'(RAM_DEPTH);

    logic [7:0] r_ram [RAM_DEPTH];

    logic       r_en;
    logic       r_ar;
    logic       r_ie;
    logic [7:0] r_reload;
    logic [7:0] r_count;
    logic [7:0] r_presc;
    logic [7:0] r_pcnt;
    logic       r_exp;
    logic [7:0] r_gpio_out;
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    logic          w_wr;
    logic          w_ram_sel;
    logic [AW-1:0] w_ram_idx;
    logic          w_wr_tctl;
    logic          w_wr_trel;
    logic          w_wr_tcnt;
    logic          w_wr_presc;
    logic          w_wr_tstat;
    logic          w_wr_gpo;
    logic          w_tick;
    logic          w_expire;
    logic [7:0]    w_rdata;

    assign w_wr       = !bus.read_write;
    assign w_ram_sel  = {1'b0, bus.address} < RAM_TOP;
    assign w_ram_idx  = bus.address[AW-1:0];
    assign w_wr_tctl  = w_wr && (bus.address == 16'hFF00);
    assign w_wr_trel  = w_wr && (bus.address == 16'hFF01);
    assign w_wr_tcnt  = w_wr && (bus.address == 16'hFF02);
    assign w_wr_presc = w_wr && (bus.address == 16'hFF03);
    assign w_wr_tstat = w_wr && (bus.address == 16'hFF04);
    assign w_wr_gpo   = w_wr && (bus.address == 16'hFF05);

    assign w_tick   = r_en && (r_pcnt == r_presc);
    assign w_expire = w_tick && (r_count == 8'd0);

    // RAM has no reset so its contents survive rst assertion
    always_ff @(posedge clk) begin
        if (w_wr && w_ram_sel) begin
            r_ram[w_ram_idx] <= bus.data_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en       <= 1'b0;
            r_ar       <= 1'b0;
            r_ie       <= 1'b0;
            r_reload   <= 8'd0;
            r_count    <= 8'd0;
            r_presc    <= 8'd0;
            r_pcnt     <= 8'd0;
            r_exp      <= 1'b0;
            r_gpio_out <= 8'd0;
            r_sync1    <= 8'd0;
            r_sync2    <= 8'd0;
        end else begin
            if (w_wr_tctl || w_wr_presc || !r_en || w_tick) begin
                r_pcnt <= 8'd0;
            end else begin
                r_pcnt <= r_pcnt + 8'd1;
            end
            // a CPU write to TCTL beats the one-shot auto-disable
            if (w_wr_tctl) begin
                r_en <= bus.data_write[0];
                r_ar <= bus.data_write[1];
                r_ie <= bus.data_write[2];
            end else if (w_expire && !r_ar) begin
                r_en <= 1'b0;
            end
            if (w_wr_trel) begin
                r_reload <= bus.data_write;
            end
            if (w_wr_tcnt) begin
                r_count <= bus.data_write;
            end else if (w_tick) begin
                if (r_count != 8'd0) begin
                    r_count <= r_count - 8'd1;
                end else if (r_ar) begin
                    r_count <= r_reload;
                end
            end
            if (w_wr_presc) begin
                r_presc <= bus.data_write;
            end
            if (w_expire) begin
                r_exp <= 1'b1;
            end else if (w_wr_tstat && bus.data_write[0]) begin
                r_exp <= 1'b0;
            end
            if (w_wr_gpo) begin
                r_gpio_out <= bus.data_write;
            end
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_rdata = 8'hFF;
        if (w_ram_sel) begin
            w_rdata = r_ram[w_ram_idx];
        end else begin
            unique case (bus.address)
                16'hFF00: w_rdata = {5'd0, r_ie, r_ar, r_en};
                16'hFF01: w_rdata = r_reload;
                16'hFF02: w_rdata = r_count;
                16'hFF03: w_rdata = r_presc;
                16'hFF04: w_rdata = {7'd0, r_exp};
                16'hFF05: w_rdata = r_gpio_out;
                16'hFF06: w_rdata = r_sync2;
                16'hFFFA: w_rdata = 8'h00;
                16'hFFFB: w_rdata = 8'h00;
                16'hFFFC: w_rdata = RESET_VECTOR[7:0];
                16'hFFFD: w_rdata = RESET_VECTOR[15:8];
                16'hFFFE: w_rdata = IRQ_VECTOR[7:0];
                16'hFFFF: w_rdata = IRQ_VECTOR[15:8];
                default:  w_rdata = 8'hFF;
            endcase
        end
    end

    assign bus.data_read = w_rdata;
    assign gpio_out      = r_gpio_out;
    assign irq           = r_exp & r_ie;
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory-mapped target on the CPU's single 8-bit data / 16-bit address bus. It answers every bus cycle the CPU issues.
- Contents: on-chip RAM, a programmable down-counting timer with interrupt, an 8-bit GPIO port, and fixed vector bytes.
- Receives address, read_write and data_write from the CPU core; drives data_read back to it.

Parameters:
- RAM_DEPTH, 2048, RAM bytes mapped from 0x0000; power of two, at most 32768.
- RESET_VECTOR, 16'h0200, value returned at 0xFFFC (low byte) / 0xFFFD (high byte).
- IRQ_VECTOR, 16'h0300, value returned at 0xFFFE (low byte) / 0xFFFF (high byte).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- address  input  16  bus address from CPU.
- read_write  input  1  1 = read, 0 = write.
- data_write  input  8  write data from CPU.
- data_read  output  8  read data to CPU.
- gpio_in  input  8  external asynchronous inputs.
- gpio_out  output  8  GPIO output register.
- irq  output  1  interrupt request, active-high, level.

Behaviour:
- Reads are combinational from address: data_read is valid in the same cycle the address is presented, so the CPU latches it on the next rising edge. data_read is driven regardless of read_write.
- Writes: when read_write=0, the target selected by address is updated on the rising clk edge.
- Memory map:
  - 0x0000 to RAM_DEPTH-1: RAM.
  - 0xFF00 TCTL: bit0 enable, bit1 auto_reload, bit2 irq_en; bits 7:3 read 0.
  - 0xFF01 TRELOAD.
  - 0xFF02 TCOUNT: read returns the live count; write loads the count.
  - 0xFF03 TPRESC.
  - 0xFF04 TSTAT: bit0 expired; writing 1 to bit0 clears it; other bits read 0.
  - 0xFF05 GPIO_OUT (read/write).
  - 0xFF06 GPIO_IN (read-only; writes ignored).
  - 0xFFFA/0xFFFB read 0x00.
  - 0xFFFC to 0xFFFF: vector bytes (read-only).
  - All other addresses: read 0xFF, writes ignored.
- Reset (rst=0, asynchronous):
  - All registers clear to 0: TCTL, TRELOAD, TCOUNT, TPRESC, expired, prescaler counter, GPIO_OUT, GPIO sync flops.
  - Outputs: gpio_out=0x00, irq=0. data_read follows the address map with cleared registers.
  - RAM contents are not reset and are undefined after power-up; RAM contents are preserved across rst assertion.
  - Reset asserted mid-count aborts the count; the timer stays stopped after release.
- GPIO input: gpio_in passes through a 2-flop synchronizer; GPIO_IN read value lags the pin by 2 cycles.
- Prescaler:
  - 8-bit counter pcnt, active only while enable=1.
  - When pcnt == TPRESC: a tick fires and pcnt returns to 0. Otherwise pcnt increments.
  - A tick therefore fires every TPRESC+1 cycles; TPRESC=0 gives a tick every cycle.
  - While enable=0, pcnt is held at 0.
  - Any write to TCTL or TPRESC clears pcnt.
- Timer on each tick:
  - If TCOUNT != 0: TCOUNT decrements.
  - If TCOUNT == 0: expired is set. Then, if auto_reload=1, TCOUNT loads TRELOAD; if auto_reload=0, TCOUNT stays 0 and enable clears to 0.
  - TCOUNT=N at enable therefore expires on tick N+1.
- Simultaneous events:
  - CPU write to TCOUNT in the same cycle as a tick: the write wins and the decrement/reload is discarded.
  - CPU write to TCTL in the same cycle as the one-shot auto-clear of enable: the written value wins.
  - TSTAT clear in the same cycle as an expiry: set wins, expired remains 1.
- irq = expired AND irq_en, driven from registers (no combinational path from bus inputs). It stays high until software clears expired or clears irq_en.
- RAM address uses address[log2(RAM_DEPTH)-1:0] only when address < RAM_DEPTH; there is no aliasing above RAM_DEPTH.

Test Plan:
- Reset/map:
  - Assert rst=0 mid-run, release.
  - Read 0xFF00..0xFF05 → all 0x00, gpio_out=0x00, irq=0.
  - Read 0xFFFC/0xFFFD → 0x00/0x02.
  - Read 0x9000 → 0xFF.
- RAM:
  - Write 0xA5 to 0x0000 and 0x5A to 0x07FF.
  - Read back same cycle as address presented → 0xA5, 0x5A.
  - Write 0x11 to 0x0800 → no RAM change; read 0x0800 → 0xFF.
- One-shot timer:
  - TPRESC=0x02, TCOUNT=0x03, TCTL=0x05.
  - expired and irq rise exactly 12 cycles after the TCTL write edge.
  - TCTL reads 0x04 (enable cleared); TCOUNT stays 0x00.
  - Write 0x01 to TSTAT → irq=0.
- Auto-reload:
  - TRELOAD=0x01, TCOUNT=0x01, TPRESC=0x00, TCTL=0x03.
  - expired sets after 2 cycles; TCOUNT reloads to 0x01 and continues.
  - irq stays 0 because irq_en=0.
- Collisions:
  - Write TCOUNT=0x40 on a tick edge → reads 0x40, not decremented.
  - Write 1 to TSTAT on an expiry edge → expired remains 1.
- GPIO:
  - Write 0x3C to 0xFF05 → gpio_out=0x3C.
  - Change gpio_in to 0x81 → 0xFF06 reads old value for 2 cycles, then 0x81.
